// File: rtl/any1_inst_align_pkg.sv
// Shared types and constants for the instruction-align stage.
// Record layouts are fixed; sInstAlignQ is the per-entry FIFO payload.
package any1_inst_align_pkg;

  localparam int pL1LineSize = 512;

  typedef logic [31:0] Instruction;

  localparam Instruction NOP_INSN = 32'h3F3F3F3F;
  localparam logic [7:0] FLT_NONE = 8'h00;
  localparam logic [7:0] FLT_IADR = 8'h36;

  // Word-select slice of ip within a 64-byte line.
  localparam int ALIGN_WIDX_HI = 5;
  localparam int ALIGN_WIDX_LO = 2;
  localparam int ALIGN_WIDX_W  = ALIGN_WIDX_HI - ALIGN_WIDX_LO + 1;

  typedef struct packed {
    logic [5:0]             stream;
    logic [31:0]            ip;
    logic [31:0]            pip;
    logic                   predict_taken;
    logic [pL1LineSize-1:0] cacheline;
  } sInstAlignIn;

  typedef struct packed {
    logic [5:0]  stream;
    logic [31:0] ip;
    logic [31:0] pip;
    logic        predict_taken;
    Instruction  ir;
  } sInstAlignOut;

  typedef struct packed {
    sInstAlignOut rec;
    logic         fault;
    logic [7:0]   cause;
  } sInstAlignQ;

endpackage

// File: rtl/any1_align_fifo.sv
// Generic synchronous FIFO with flush and occupancy count.
// Read data is registered storage; it reads as zero whenever the FIFO is empty.
module any1_align_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Flush wins over both push and pop in the same cycle.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

  // Masking keeps uninitialised storage from ever reaching the outputs.
  assign rdata_o = empty_o ? '0 : mem[rd_ptr];

endmodule

// File: rtl/any1_inst_align.sv
// Instruction-align stage: picks the 32-bit word at ip from a cache line, flags misalignment.
// Latency 1 cycle through the FIFO; in_ready_o drops when full or flushing, independent of out_ready_i.
module any1_inst_align
  import any1_inst_align_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LINEW = 512
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [$bits(sInstAlignIn)-1:0]  in_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [$bits(sInstAlignOut)-1:0] out_o,
  output logic                            out_fault_o,
  output logic [7:0]                      out_cause_o,
  output logic [$clog2(DEPTH):0]          count_o
);

  if (LINEW != pL1LineSize) begin : g_linew_check
    $error("LINEW must equal pL1LineSize");
  end

  sInstAlignIn             in_rec;
  sInstAlignQ              q_in;
  sInstAlignQ              q_out;
  logic [ALIGN_WIDX_W-1:0] widx;
  Instruction              word;
  logic                    misalign;
  logic                    fifo_full;
  logic                    fifo_empty;

  assign in_rec   = in_i;
  assign widx     = in_rec.ip[ALIGN_WIDX_HI:ALIGN_WIDX_LO];
  assign word     = in_rec.cacheline[{widx, 5'd0} +: 32];
  assign misalign = |in_rec.ip[1:0];

  always_comb begin
    q_in                   = '0;
    q_in.rec.stream        = in_rec.stream;
    q_in.rec.ip            = in_rec.ip;
    q_in.rec.pip           = in_rec.pip;
    q_in.rec.predict_taken = in_rec.predict_taken;
    q_in.rec.ir            = misalign ? NOP_INSN : word;
    q_in.fault             = misalign;
    q_in.cause             = misalign ? FLT_IADR : FLT_NONE;
  end

  // rst_ni term holds ready low for the whole time reset is asserted.
  assign in_ready_o = rst_ni && !fifo_full && !flush_i;

  any1_align_fifo #(
    .WIDTH($bits(sInstAlignQ)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (in_valid_i && in_ready_o),
    .pop_i   (out_ready_i),
    .wdata_i (q_in),
    .rdata_o (q_out),
    .count_o (count_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid_o = !fifo_empty;
  assign out_o       = q_out.rec;
  assign out_fault_o = q_out.fault;
  assign out_cause_o = q_out.cause;

endmodule
